// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
//   dmem_size_e  : request access size, encoded {size_1, size_0}
//   dmem_state_e : responder FSM state
//   LATENCY_MIN/LATENCY_MAX : legal range of the load latency parameter
//   is_misaligned/byte_enables/lane_data : request decode helpers
package dmem_pkg;

    localparam int unsigned LATENCY_MIN = 1;
    localparam int unsigned LATENCY_MAX = 4;

    // Wide enough to hold LATENCY_MAX - 1.
    localparam int unsigned CNT_W = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } dmem_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    // Reserved size is treated the same as a misaligned access.
    function automatic logic is_misaligned(input dmem_size_e size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_enables(input dmem_size_e size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << offset;
            SZ_HALF: be = offset[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate right-aligned store data across every lane it could land in, so the
    // byte enables alone select the destination.
    function automatic logic [31:0] lane_data(input dmem_size_e size, input logic [31:0] data);
        logic [31:0] lanes;
        case (size)
            SZ_BYTE: lanes = {4{data[7:0]}};
            SZ_HALF: lanes = {2{data[15:0]}};
            default: lanes = data;
        endcase
        return lanes;
    endfunction

endpackage

// File: rtl/dmem_sram_bank.sv
// Word-organised storage array with per-byte write enables.
//   clock   : write clock (writes take effect on the rising edge)
//   wr_be   : byte-lane write enables, lane 0 = bits [7:0]
//   wr_idx  : word index written
//   wr_data : write data, already lane-aligned
//   rd_idx  : word index read
//   rd_data : combinational read data
// Contents are not reset.
module dmem_sram_bank #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clock,
    input  logic [3:0]                     wr_be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] wr_idx,
    input  logic [31:0]                    wr_data,
    input  logic [$clog2(DEPTH_WORDS)-1:0] rd_idx,
    output logic [31:0]                    rd_data
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Single-port data-memory responder: stores complete on the accept edge, loads return
// a one-cycle response pulse a fixed LATENCY cycles after acceptance.
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   dmem_req_valid      : request present
//   dmem_req_we         : 1 = store, 0 = load
//   dmem_req_addr       : byte address (bits above the word index are ignored)
//   dmem_req_data       : right-aligned store data
//   dmem_req_size_0/_1  : access size {size_1, size_0}
//   dmem_req_ready      : request can be accepted this cycle (IDLE only)
//   dmem_resp_valid     : one-cycle load response pulse
//   dmem_resp_data      : full aligned word of the load, 0 when not valid
//   misaligned_err      : sticky flag for misaligned or reserved-size requests
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dmem_req_valid,
    input  logic        dmem_req_we,
    input  logic [31:0] dmem_req_addr,
    input  logic [31:0] dmem_req_data,
    input  logic        dmem_req_size_0,
    input  logic        dmem_req_size_1,
    output logic        dmem_req_ready,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_data,
    output logic        misaligned_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
        $error("dmem_responder: LATENCY must be within 1..4");
    end

    if (DEPTH_WORDS < 16 || DEPTH_WORDS > 65536 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("dmem_responder: DEPTH_WORDS must be a power of two within 16..65536");
    end

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bad_q, bad_d;
    logic             err_q, err_d;

    dmem_size_e       req_size;
    logic [IDX_W-1:0] req_idx;
    logic             req_bad;
    logic             accept;
    logic [3:0]       wr_be;
    logic [31:0]      wr_data;
    logic [31:0]      rd_data;
    logic             unused_addr_hi;

    assign req_size = dmem_size_e'({dmem_req_size_1, dmem_req_size_0});
    assign req_idx  = dmem_req_addr[2 +: IDX_W];
    assign req_bad  = is_misaligned(req_size, dmem_req_addr[1:0]);
    assign accept   = dmem_req_valid & dmem_req_ready;
    assign wr_data  = lane_data(req_size, dmem_req_data);

    // Upper address bits alias onto the array and are deliberately dropped.
    assign unused_addr_hi = ^dmem_req_addr[31:IDX_W+2];

    dmem_sram_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clock   (clock),
        .wr_be   (wr_be),
        .wr_idx  (req_idx),
        .wr_data (wr_data),
        .rd_idx  (idx_q),
        .rd_data (rd_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        bad_d   = bad_q;
        err_d   = err_q;
        wr_be   = 4'b0000;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_bad) begin
                        err_d = 1'b1;
                    end
                    if (dmem_req_we) begin
                        // Stores finish on this edge; stay in IDLE for back-to-back stores.
                        if (!req_bad) begin
                            wr_be = byte_enables(req_size, dmem_req_addr[1:0]);
                        end
                    end else begin
                        idx_d = req_idx;
                        bad_d = req_bad;
                        if (LATENCY == LATENCY_MIN) begin
                            state_d = RESP;
                            cnt_d   = '0;
                        end else begin
                            state_d = WAIT;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
            end
            WAIT: begin
                // cnt_q counts the edges left until RESP is entered.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign dmem_req_ready  = (state_q == IDLE);
    assign dmem_resp_valid = (state_q == RESP);
    assign dmem_resp_data  = (dmem_resp_valid && !bad_q) ? rd_data : 32'h0;
    assign misaligned_err  = err_q;

endmodule
